// File: rtl/mem_bus_arbiter_if.sv
// Bundles the CPU, DMA and memory side signals of the memory port arbiter.
// The master modport is the view of whoever drives the requests and models
// memory (the bench). The slave modport is the arbiter's view.
interface mem_bus_if;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_byte;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_ack;
    logic [31:0] rdata;
    logic        mem_read;
    logic [1:0]  mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        owner;

    modport master (
        output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_ack, dma_ack, rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  busy, owner
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_ack, dma_ack, rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output busy, owner
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Memory port arbiter shared by the CPU and the DMA engine.
// Each access runs issue -> wait MEM_LAT -> ack -> one idle cycle. The CPU has
// fixed priority, but after MAX_SKIP consecutive CPU grants while DMA is
// waiting, the DMA is granted. Every output is a register.
module mem_bus_arbiter #(
    parameter int MEM_LAT  = 2,
    parameter int MAX_SKIP = 4
) (
    input  logic      clk,
    input  logic      rst,
    mem_bus_if.slave  bus
);

    localparam int CNT_W  = $clog2(MEM_LAT + 1);
    localparam int SKIP_W = $clog2(MAX_SKIP + 1);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic [SKIP_W-1:0] SKIP_LIM = SKIP_W'(MAX_SKIP);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [SKIP_W-1:0]   skip, skip_n;
    logic                lat_we, lat_we_n;
    logic                lat_byte, lat_byte_n;
    logic                owner_n;
    logic                grant_dma, grant_cpu;
    logic                mem_read_n;
    logic [1:0]          mem_write_n;
    logic [31:0]         mem_addr_n, mem_wdata_n, rdata_n;
    logic                cpu_ack_n, dma_ack_n;

    // Next-state, arbitration and registered-output values
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        skip_n      = skip;
        lat_we_n    = lat_we;
        lat_byte_n  = lat_byte;
        owner_n     = bus.owner;
        mem_read_n  = 1'b0;
        mem_write_n = 2'd0;
        mem_addr_n  = bus.mem_addr;
        mem_wdata_n = bus.mem_wdata;
        rdata_n     = bus.rdata;
        cpu_ack_n   = 1'b0;
        dma_ack_n   = 1'b0;
        grant_dma   = 1'b0;
        grant_cpu   = 1'b0;

        unique case (state)
            IDLE: begin
                grant_dma = bus.dma_req && (!bus.cpu_req || skip == SKIP_LIM);
                grant_cpu = !grant_dma && bus.cpu_req;
                if (grant_dma) begin
                    owner_n    = 1'b1;
                    lat_we_n   = bus.dma_we;
                    lat_byte_n = 1'b0;
                    mem_addr_n = bus.dma_addr;
                    skip_n     = '0;
                    if (bus.dma_we) begin
                        mem_write_n = 2'd2;
                        mem_wdata_n = bus.dma_wdata;
                    end else begin
                        mem_read_n = 1'b1;
                    end
                end else if (grant_cpu) begin
                    owner_n    = 1'b0;
                    lat_we_n   = bus.cpu_we;
                    lat_byte_n = bus.cpu_byte;
                    mem_addr_n = bus.cpu_addr;
                    // Count CPU wins only while the DMA is actually waiting
                    if (bus.dma_req)
                        skip_n = (skip == SKIP_LIM) ? skip : skip + 1'b1;
                    else
                        skip_n = '0;
                    if (bus.cpu_we) begin
                        mem_write_n = bus.cpu_byte ? 2'd3 : 2'd1;
                        mem_wdata_n = bus.cpu_wdata;
                    end else begin
                        mem_read_n = 1'b1;
                    end
                end
                if (grant_dma || grant_cpu) begin
                    cnt_n   = CNT_INIT;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    if (!lat_we)
                        rdata_n = lat_byte ? {24'b0, bus.mem_rdata[7:0]} : bus.mem_rdata;
                    cpu_ack_n = !bus.owner;
                    dma_ack_n = bus.owner;
                    state_n   = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers, all cleared by the active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            skip          <= '0;
            lat_we        <= 1'b0;
            lat_byte      <= 1'b0;
            bus.owner     <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 2'd0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rdata     <= '0;
            bus.cpu_ack   <= 1'b0;
            bus.dma_ack   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            skip          <= skip_n;
            lat_we        <= lat_we_n;
            lat_byte      <= lat_byte_n;
            bus.owner     <= owner_n;
            bus.mem_read  <= mem_read_n;
            bus.mem_write <= mem_write_n;
            bus.mem_addr  <= mem_addr_n;
            bus.mem_wdata <= mem_wdata_n;
            bus.rdata     <= rdata_n;
            bus.cpu_ack   <= cpu_ack_n;
            bus.dma_ack   <= dma_ack_n;
            bus.busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with MEM_LAT=2, MAX_SKIP=4.
module tb_mem_bus_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   n_rd;
    int   n_ack;
    logic counting;
    logic [9:0] pattern;

    mem_bus_if bus ();

    mem_bus_arbiter #(.MEM_LAT(2), .MAX_SKIP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
        if (counting) begin
            if (bus.mem_read) n_rd++;
            if (bus.cpu_ack)  n_ack++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_ack"},   {31'b0, bus.cpu_ack},   32'd0);
        check({tag, "_dma_ack"},   {31'b0, bus.dma_ack},   32'd0);
        check({tag, "_rdata"},     bus.rdata,              32'd0);
        check({tag, "_mem_read"},  {31'b0, bus.mem_read},  32'd0);
        check({tag, "_mem_write"}, {30'b0, bus.mem_write}, 32'd0);
        check({tag, "_mem_addr"},  bus.mem_addr,           32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata,          32'd0);
        check({tag, "_busy"},      {31'b0, bus.busy},      32'd0);
        check({tag, "_owner"},     {31'b0, bus.owner},     32'd0);
    endtask

    initial begin
        total = 0; bad = 0; n_rd = 0; n_ack = 0; counting = 1'b0;
        rst = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_byte = 1'b0;
        bus.cpu_addr = '0;  bus.cpu_wdata = '0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0;
        bus.dma_addr = '0;  bus.dma_wdata = '0;
        bus.mem_rdata = '0;

        // Reset state
        step(); step();
        check_all_zero("reset");
        rst = 1'b1;
        step();

        // T1: CPU word read
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_byte = 1'b0;
        bus.cpu_addr = 32'h10; bus.mem_rdata = 32'hDEADBEEF;
        step();
        check("t1_mem_read_g",  {31'b0, bus.mem_read}, 32'd1);
        check("t1_mem_addr",    bus.mem_addr,          32'h10);
        check("t1_busy",        {31'b0, bus.busy},     32'd1);
        check("t1_owner",       {31'b0, bus.owner},    32'd0);
        step();
        check("t1_mem_read_g1", {31'b0, bus.mem_read}, 32'd0);
        check("t1_ack_early",   {31'b0, bus.cpu_ack},  32'd0);
        step();
        check("t1_cpu_ack",     {31'b0, bus.cpu_ack},  32'd1);
        check("t1_dma_ack",     {31'b0, bus.dma_ack},  32'd0);
        check("t1_rdata",       bus.rdata,             32'hDEADBEEF);
        bus.cpu_req = 1'b0;
        step();
        check("t1_ack_drop",    {31'b0, bus.cpu_ack},  32'd0);
        check("t1_busy_end",    {31'b0, bus.busy},     32'd0);

        // T2: CPU byte write then byte read
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_byte = 1'b1;
        bus.cpu_addr = 32'h23; bus.cpu_wdata = 32'h000000A5;
        step();
        check("t2_mem_write",   {30'b0, bus.mem_write}, 32'd3);
        check("t2_mem_read",    {31'b0, bus.mem_read},  32'd0);
        check("t2_mem_addr",    bus.mem_addr,           32'h23);
        check("t2_mem_wdata",   bus.mem_wdata,          32'hA5);
        step();
        check("t2_mem_write_1", {30'b0, bus.mem_write}, 32'd0);
        step();
        check("t2_wr_ack",      {31'b0, bus.cpu_ack},   32'd1);
        check("t2_wr_rdata",    bus.rdata,              32'hDEADBEEF);
        bus.cpu_req = 1'b0;
        step();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_byte = 1'b1;
        bus.mem_rdata = 32'h123456EF;
        step();
        check("t2_rd_strobe",   {31'b0, bus.mem_read},  32'd1);
        check("t2_wdata_hold",  bus.mem_wdata,          32'hA5);
        step(); step();
        check("t2_rd_ack",      {31'b0, bus.cpu_ack},   32'd1);
        check("t2_rd_rdata",    bus.rdata,              32'h000000EF);
        bus.cpu_req = 1'b0; bus.cpu_byte = 1'b0;
        step();

        // T3: DMA word write alone
        bus.dma_req = 1'b1; bus.dma_we = 1'b1;
        bus.dma_addr = 32'h400; bus.dma_wdata = 32'hCAFEF00D;
        step();
        check("t3_mem_write",   {30'b0, bus.mem_write}, 32'd2);
        check("t3_mem_addr",    bus.mem_addr,           32'h400);
        check("t3_mem_wdata",   bus.mem_wdata,          32'hCAFEF00D);
        check("t3_owner",       {31'b0, bus.owner},     32'd1);
        step(); step();
        check("t3_dma_ack",     {31'b0, bus.dma_ack},   32'd1);
        check("t3_cpu_ack",     {31'b0, bus.cpu_ack},   32'd0);
        bus.dma_req = 1'b0;
        step();
        check("t3_dma_ack_drop", {31'b0, bus.dma_ack},  32'd0);

        // T4: both masters requesting continuously -> C,C,C,C,D,C,C,C,C,D
        pattern = 10'b1000010000;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h100;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h800;
        bus.mem_rdata = 32'h0BADF00D;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("t4_owner_%0d", i), {31'b0, bus.owner}, {31'b0, pattern[i]});
            step(); step();
            check($sformatf("t4_cpu_ack_%0d", i), {31'b0, bus.cpu_ack}, {31'b0, !pattern[i]});
            check($sformatf("t4_dma_ack_%0d", i), {31'b0, bus.dma_ack}, {31'b0, pattern[i]});
            if (i == 9) begin
                bus.cpu_req = 1'b0;
                bus.dma_req = 1'b0;
            end
            step();
        end

        // T5: reset while waiting abandons the access
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h50;
        step();
        check("t5_strobe",      {31'b0, bus.mem_read},  32'd1);
        rst = 1'b0;
        step();
        check_all_zero("t5_rst");
        rst = 1'b1;
        bus.mem_rdata = 32'h55AA55AA;
        step();
        check("t5_regrant",     {31'b0, bus.mem_read},  32'd1);
        check("t5_regrant_addr", bus.mem_addr,          32'h50);
        step(); step();
        check("t5_ack",         {31'b0, bus.cpu_ack},   32'd1);
        check("t5_rdata",       bus.rdata,              32'h55AA55AA);
        bus.cpu_req = 1'b0;
        step();

        // T6: CPU re-requests right after ack, second access issues at DONE+1
        counting = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h60; bus.mem_rdata = 32'h11111111;
        step(); step(); step();
        check("t6_ack1",        {31'b0, bus.cpu_ack},   32'd1);
        bus.cpu_req = 1'b0;
        step();
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h64; bus.mem_rdata = 32'h22222222;
        step();
        check("t6_second_issue", {31'b0, bus.mem_read}, 32'd1);
        check("t6_second_addr", bus.mem_addr,           32'h64);
        step(); step();
        check("t6_ack2_rdata",  bus.rdata,              32'h22222222);
        bus.cpu_req = 1'b0;
        step(); step(); step();
        counting = 1'b0;
        check("t6_read_pulses", n_rd,                   32'd2);
        check("t6_ack_pulses",  n_ack,                  32'd2);
        check("t6_idle",        {31'b0, bus.busy},      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
